// File: rtl/run_ctrl.sv
// run_ctrl: run-mode controller for a datapath core.
// Sequences the core reset, then gates the core clock enable for free-run,
// step-N and run-to-breakpoint runs. All outputs come straight from flops.
module run_ctrl #(
    parameter int unsigned N          = 32,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned RST_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic             start,
    input  logic [CNT_W-1:0] step_count,
    input  logic [N-1:0]     bp_addr,
    input  logic [N-1:0]     pc,
    input  logic             halt_req,
    input  logic             soft_rst,
    output logic             core_rst,
    output logic             core_en,
    output logic             busy,
    output logic             done,
    output logic             bp_hit,
    output logic [CNT_W-1:0] cycles
);

    // Reset-sequence counter is sized for the full 1..255 range of RST_CYCLES.
    localparam int unsigned      RC_W    = 8;
    localparam logic [RC_W-1:0]  RC_LAST = RC_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    localparam logic [1:0] MODE_RUN  = 2'b01;
    localparam logic [1:0] MODE_STEP = 2'b10;
    localparam logic [1:0] MODE_BRK  = 2'b11;

    typedef enum logic [2:0] {
        S_RSTSEQ = 3'd0,
        S_IDLE   = 3'd1,
        S_RUN    = 3'd2,
        S_STEP   = 3'd3,
        S_BRK    = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [RC_W-1:0]  r_rst_cnt;
    logic [RC_W-1:0]  w_rst_cnt_nxt;
    logic [CNT_W-1:0] r_remaining;
    logic [CNT_W-1:0] w_remaining_nxt;
    logic [CNT_W-1:0] r_cycles;
    logic [CNT_W-1:0] w_cycles_nxt;

    logic r_core_rst;
    logic r_core_en;
    logic r_busy;
    logic r_done;
    logic r_bp_hit;

    logic w_done_nxt;
    logic w_bp_hit_nxt;
    logic w_accept;
    logic w_active_nxt;
    logic w_pc_match;
    logic w_last_step;

    assign w_pc_match  = (pc == bp_addr);
    assign w_last_step = (r_remaining == CNT_ONE);

    // Next-state decode; soft_rst outranks everything, then halt, then run end, then start.
    always_comb begin
        w_state_nxt     = r_state;
        w_rst_cnt_nxt   = r_rst_cnt;
        w_remaining_nxt = r_remaining;
        w_done_nxt      = 1'b0;
        w_bp_hit_nxt    = r_bp_hit;
        w_accept        = 1'b0;

        if (soft_rst) begin
            // Abort without a done pulse; cycles and bp_hit are kept.
            w_state_nxt     = S_RSTSEQ;
            w_rst_cnt_nxt   = '0;
            w_remaining_nxt = '0;
        end else begin
            case (r_state)
                S_RSTSEQ: begin
                    if (r_rst_cnt >= RC_LAST) begin
                        w_state_nxt   = S_IDLE;
                        w_rst_cnt_nxt = '0;
                    end else begin
                        w_rst_cnt_nxt = r_rst_cnt + RC_W'(1);
                    end
                end

                S_IDLE: begin
                    // halt_req alone is a no-op here, but it still outranks a start.
                    if (start && !halt_req) begin
                        case (mode)
                            MODE_RUN: begin
                                w_accept    = 1'b1;
                                w_state_nxt = S_RUN;
                            end
                            MODE_STEP: begin
                                w_accept = 1'b1;
                                if (step_count != '0) begin
                                    w_state_nxt     = S_STEP;
                                    w_remaining_nxt = step_count;
                                end else begin
                                    // Zero-length step: finish immediately, core stays off.
                                    w_done_nxt = 1'b1;
                                end
                            end
                            MODE_BRK: begin
                                w_accept    = 1'b1;
                                w_state_nxt = S_BRK;
                            end
                            default: begin
                            end
                        endcase
                    end
                end

                S_RUN: begin
                    if (halt_req) begin
                        w_state_nxt = S_IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end

                S_STEP: begin
                    if (halt_req) begin
                        w_state_nxt     = S_IDLE;
                        w_done_nxt      = 1'b1;
                        w_remaining_nxt = '0;
                    end else begin
                        w_remaining_nxt = r_remaining - CNT_ONE;
                        if (w_last_step) begin
                            w_state_nxt = S_IDLE;
                            w_done_nxt  = 1'b1;
                            // A breakpoint landing on the final step is reported as a breakpoint.
                            if (w_pc_match) begin
                                w_bp_hit_nxt = 1'b1;
                            end
                        end
                    end
                end

                S_BRK: begin
                    if (halt_req) begin
                        w_state_nxt = S_IDLE;
                        w_done_nxt  = 1'b1;
                    end else if (w_pc_match) begin
                        w_state_nxt  = S_IDLE;
                        w_done_nxt   = 1'b1;
                        w_bp_hit_nxt = 1'b1;
                    end
                end

                default: begin
                    w_state_nxt = S_RSTSEQ;
                end
            endcase
        end

        if (w_accept) begin
            w_bp_hit_nxt = 1'b0;
        end
    end

    // Enabled-cycle counter: cleared on an accepted start, saturating, frozen when the core is off.
    always_comb begin
        w_cycles_nxt = r_cycles;
        if (w_accept) begin
            w_cycles_nxt = '0;
        end else if (r_core_en && (r_cycles != CNT_MAX)) begin
            w_cycles_nxt = r_cycles + CNT_ONE;
        end
    end

    assign w_active_nxt = (w_state_nxt == S_RUN) || (w_state_nxt == S_STEP) ||
                          (w_state_nxt == S_BRK);

    // State and counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_RSTSEQ;
            r_rst_cnt   <= '0;
            r_remaining <= '0;
            r_cycles    <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_rst_cnt   <= w_rst_cnt_nxt;
            r_remaining <= w_remaining_nxt;
            r_cycles    <= w_cycles_nxt;
        end
    end

    // Output registers, decoded from the next state so they line up with the state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_core_rst <= 1'b1;
            r_core_en  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_bp_hit   <= 1'b0;
        end else begin
            r_core_rst <= (w_state_nxt == S_RSTSEQ);
            r_core_en  <= w_active_nxt;
            r_busy     <= w_active_nxt;
            r_done     <= w_done_nxt;
            r_bp_hit   <= w_bp_hit_nxt;
        end
    end

    assign core_rst = r_core_rst;
    assign core_en  = r_core_en;
    assign busy     = r_busy;
    assign done     = r_done;
    assign bp_hit   = r_bp_hit;
    assign cycles   = r_cycles;

endmodule

// File: tb/tb_run_ctrl.sv
// tb_run_ctrl: directed and randomized checks of run_ctrl against a
// cycle-level behavioural model of the run-mode rules.
module tb_run_ctrl;

    localparam int N          = 32;
    localparam int CNT_W      = 16;
    localparam int RST_CYCLES = 4;
    localparam int CNT_MAX    = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst;
    logic [1:0]       mode;
    logic             start;
    logic [CNT_W-1:0] step_count;
    logic [N-1:0]     bp_addr;
    logic [N-1:0]     pc;
    logic             halt_req;
    logic             soft_rst;
    logic             core_rst;
    logic             core_en;
    logic             busy;
    logic             done;
    logic             bp_hit;
    logic [CNT_W-1:0] cycles;

    // Narrow-counter instance for the saturation case.
    logic [1:0] mode4;
    logic       start4;
    logic [3:0] step4;
    logic [7:0] bp4;
    logic [7:0] pc4;
    logic       halt4;
    logic       soft4;
    logic       core_rst4;
    logic       core_en4;
    logic       busy4;
    logic       done4;
    logic       bp_hit4;
    logic [3:0] cycles4;

    int checks = 0;
    int errors = 0;

    // Behavioural model state.
    int m_rst_left;
    bit m_active;
    int m_kind;
    int m_left;
    int m_cycles;
    bit m_bp;
    bit m_done;

    run_ctrl #(.N(N), .CNT_W(CNT_W), .RST_CYCLES(RST_CYCLES)) u_dut (
        .clk(clk), .rst(rst), .mode(mode), .start(start), .step_count(step_count),
        .bp_addr(bp_addr), .pc(pc), .halt_req(halt_req), .soft_rst(soft_rst),
        .core_rst(core_rst), .core_en(core_en), .busy(busy), .done(done),
        .bp_hit(bp_hit), .cycles(cycles)
    );

    run_ctrl #(.N(8), .CNT_W(4), .RST_CYCLES(2)) u_dut4 (
        .clk(clk), .rst(rst), .mode(mode4), .start(start4), .step_count(step4),
        .bp_addr(bp4), .pc(pc4), .halt_req(halt4), .soft_rst(soft4),
        .core_rst(core_rst4), .core_en(core_en4), .busy(busy4), .done(done4),
        .bp_hit(bp_hit4), .cycles(cycles4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_rst_left = RST_CYCLES;
        m_active   = 1'b0;
        m_kind     = 0;
        m_left     = 0;
        m_cycles   = 0;
        m_bp       = 1'b0;
        m_done     = 1'b0;
    endtask

    // One rising edge of the rules, using the inputs currently applied.
    task automatic model_step();
        bit nd;
        nd = 1'b0;
        if (m_active) m_cycles++;
        if (soft_rst) begin
            m_rst_left = RST_CYCLES;
            m_active   = 1'b0;
        end else if (m_rst_left > 0) begin
            m_rst_left--;
        end else if (m_active) begin
            if (halt_req) begin
                m_active = 1'b0;
                nd       = 1'b1;
            end else if (m_kind == 2) begin
                m_left--;
                if (m_left == 0) begin
                    m_active = 1'b0;
                    nd       = 1'b1;
                    if (pc == bp_addr) m_bp = 1'b1;
                end
            end else if (m_kind == 3 && pc == bp_addr) begin
                m_active = 1'b0;
                nd       = 1'b1;
                m_bp     = 1'b1;
            end
        end else if (start && !halt_req && mode != 2'b00) begin
            m_cycles = 0;
            m_bp     = 1'b0;
            if (mode == 2'b10 && step_count == '0) begin
                nd = 1'b1;
            end else begin
                m_active = 1'b1;
                m_kind   = int'(mode);
                m_left   = int'(step_count);
            end
        end
        m_done = nd;
    endtask

    task automatic check_all();
        int ec;
        ec = (m_cycles > CNT_MAX) ? CNT_MAX : m_cycles;
        chk("core_rst", 32'(core_rst), 32'(m_rst_left > 0));
        chk("core_en",  32'(core_en),  32'(m_active));
        chk("busy",     32'(busy),     32'(m_active));
        chk("done",     32'(done),     32'(m_done));
        chk("bp_hit",   32'(bp_hit),   32'(m_bp));
        chk("cycles",   32'(cycles),   32'(ec));
    endtask

    // Advance one clock; the emulated core moves pc on by 4 per enabled cycle.
    task automatic tick();
        bit en_b;
        en_b = m_active;
        model_step();
        @(posedge clk);
        @(negedge clk);
        if (en_b) pc = pc + 32'd4;
        check_all();
    endtask

    // Issue the pending start and observe n cycles, counting enabled and done cycles.
    task automatic watch(input int n, output int en_cnt, output int done_cnt);
        en_cnt   = 0;
        done_cnt = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            start = 1'b0;
            if (core_en) en_cnt++;
            if (done) done_cnt++;
        end
    endtask

    task automatic hard_reset_mid();
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int n;
        int en;
        int dn;
        int r;

        rst = 1'b0; mode = 2'b00; start = 1'b0; step_count = '0;
        bp_addr = 32'hFFFF_FFF0; pc = '0; halt_req = 1'b0; soft_rst = 1'b0;
        mode4 = 2'b01; start4 = 1'b0; step4 = '0; bp4 = 8'hFF; pc4 = '0;
        halt4 = 1'b0; soft4 = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_all();
        chk("reset_core_rst", 32'(core_rst), 32'd1);
        chk("reset_cycles",   32'(cycles),   32'd0);

        // Reset sequence length after release.
        rst = 1'b1;
        n   = 0;
        for (int i = 0; i < 20; i++) begin
            if (!core_rst) break;
            n++;
            tick();
        end
        chk("rstseq_len", 32'(n), 32'(RST_CYCLES));

        // Step-5 run.
        mode = 2'b10; step_count = 16'd5; start = 1'b1;
        watch(8, en, dn);
        chk("step5_en",     32'(en),     32'd5);
        chk("step5_done",   32'(dn),     32'd1);
        chk("step5_cycles", 32'(cycles), 32'd5);
        chk("step5_bp",     32'(bp_hit), 32'd0);

        // Zero-length step.
        step_count = '0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("step0_done", 32'(done),    32'd1);
        chk("step0_en",   32'(core_en), 32'd0);
        tick();
        chk("step0_done_clr", 32'(done), 32'd0);

        // Breakpoint at 0x10 with pc from 0.
        pc = '0; bp_addr = 32'h10; mode = 2'b11; start = 1'b1;
        watch(8, en, dn);
        chk("brk_en",     32'(en),     32'd5);
        chk("brk_done",   32'(dn),     32'd1);
        chk("brk_bp",     32'(bp_hit), 32'd1);
        chk("brk_cycles", 32'(cycles), 32'd5);

        // Breakpoint already matching in the first cycle.
        bp_addr = pc; start = 1'b1;
        watch(4, en, dn);
        chk("brk1_en", 32'(en),     32'd1);
        chk("brk1_bp", 32'(bp_hit), 32'd1);

        // Breakpoint and step expiry on the same edge.
        bp_addr = pc + 32'd16; mode = 2'b10; step_count = 16'd5; start = 1'b1;
        watch(8, en, dn);
        chk("stepbp_en", 32'(en),     32'd5);
        chk("stepbp_bp", 32'(bp_hit), 32'd1);

        // halt_req while idle does nothing.
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        chk("idle_halt_bp", 32'(bp_hit), 32'd1);

        // Free run halted in the 7th enabled cycle, with an ignored start mid-run.
        bp_addr = 32'hFFFF_FFF0; mode = 2'b01; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        start = 1'b1; mode = 2'b10; step_count = 16'd3;
        tick();
        start = 1'b0;
        repeat (3) tick();
        chk("run_busy", 32'(busy), 32'd1);
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        chk("run_cycles", 32'(cycles),  32'd7);
        chk("run_done",   32'(done),    32'd1);
        chk("run_en",     32'(core_en), 32'd0);

        // soft_rst during the 2nd cycle of a 3-step run.
        mode = 2'b10; step_count = 16'd3; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        soft_rst = 1'b1;
        tick();
        soft_rst = 1'b0;
        chk("soft_core_rst", 32'(core_rst), 32'd1);
        chk("soft_done",     32'(done),     32'd0);
        chk("soft_cycles",   32'(cycles),   32'd2);
        repeat (RST_CYCLES) tick();
        chk("soft_rst_end", 32'(core_rst), 32'd0);

        // Hard reset in the middle of a breakpoint run.
        mode = 2'b11; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        hard_reset_mid();
        chk("rstbrk_en",     32'(core_en), 32'd0);
        chk("rstbrk_cycles", 32'(cycles),  32'd0);
        repeat (RST_CYCLES) tick();

        // Randomized traffic against the model.
        for (int it = 0; it < 1500; it++) begin
            r          = int'($urandom_range(0, 99));
            soft_rst   = (r < 2);
            start      = (r >= 2 && r < 17);
            halt_req   = (r >= 17 && r < 22);
            mode       = 2'($urandom_range(0, 3));
            step_count = 16'($urandom_range(0, 6));
            if (start && !m_active) begin
                if (mode == 2'b10) begin
                    if ($urandom_range(0, 1) == 1)
                        bp_addr = pc + 32'(4 * (int'(step_count) - 1));
                    else
                        bp_addr = 32'hFFFF_FFF0;
                end else if (mode == 2'b11) begin
                    bp_addr = pc + 32'(4 * int'($urandom_range(0, 8)));
                end
            end
            if ($urandom_range(0, 199) == 0) hard_reset_mid();
            else tick();
        end
        start = 1'b0; halt_req = 1'b0; soft_rst = 1'b0;
        repeat (5) tick();

        // Saturation of a 4-bit cycle counter.
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        repeat (10) tick();
        chk("sat_mid", 32'(cycles4), 32'd10);
        repeat (10) tick();
        chk("sat_full", 32'(cycles4),  32'd15);
        chk("sat_en",   32'(core_en4), 32'd1);
        halt4 = 1'b1;
        tick();
        halt4 = 1'b0;
        chk("sat_hold", 32'(cycles4), 32'd15);
        chk("sat_done", 32'(done4),   32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
